// File: rtl/ff_chk_pkg.sv
// Shared definitions for the flop-legalization checker: FSM encoding,
// per-bit flop descriptors for the 27 variants, and small helper functions.
package ff_chk_pkg;

  localparam int NBITS = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_e;

  localparam int IDX_DFF     = 0;
  localparam int IDX_DFFE    = 2;
  localparam int IDX_SDFF0   = 5;
  localparam int IDX_SDFF1   = 8;
  localparam int IDX_SDFFE0  = 11;
  localparam int IDX_SDFFE1  = 15;
  localparam int IDX_SDFFCE0 = 19;
  localparam int IDX_SDFFCE1 = 23;

  function automatic logic [NBITS-1:0] span_mask(input int lo, input int hi);
    logic [NBITS-1:0] m;
    m = {NBITS{1'b0}};
    for (int i = 0; i < NBITS; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [NBITS-1:0] bit_mask(input int n);
    return span_mask(n, n);
  endfunction

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [4:0] lowest_set(input logic [NBITS-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  localparam logic [NBITS-1:0] CLK_NEG_MASK =
    bit_mask(1) | bit_mask(4) | bit_mask(7) | bit_mask(10) |
    bit_mask(14) | bit_mask(18) | bit_mask(22) | bit_mask(26);
  localparam logic [NBITS-1:0] EN_USED_MASK =
    span_mask(IDX_DFFE, IDX_SDFF0 - 1) | span_mask(IDX_SDFFE0, NBITS - 1);
  localparam logic [NBITS-1:0] EN_NEG_MASK =
    bit_mask(3) | bit_mask(12) | bit_mask(16) | bit_mask(20) | bit_mask(24);
  localparam logic [NBITS-1:0] RST_USED_MASK = span_mask(IDX_SDFF0, NBITS - 1);
  localparam logic [NBITS-1:0] RST_NEG_MASK =
    bit_mask(6) | bit_mask(9) | bit_mask(13) | bit_mask(17) | bit_mask(21) | bit_mask(25);
  localparam logic [NBITS-1:0] RST_VAL_MASK =
    span_mask(IDX_SDFF1, IDX_SDFFE0 - 1) | span_mask(IDX_SDFFE1, IDX_SDFFCE0 - 1) |
    span_mask(IDX_SDFFCE1, NBITS - 1);
  localparam logic [NBITS-1:0] CE_PRIO_MASK = span_mask(IDX_SDFFCE0, NBITS - 1);

endpackage

// File: rtl/ff_chk_model.sv
// Generic behavioural flop model: one instance per flop variant, configured by
// descriptor bits. Reports the expected Q and whether it has ever been loaded.
module ff_chk_model #(
  parameter logic CLK_NEG  = 1'b0,
  parameter logic EN_USED  = 1'b0,
  parameter logic EN_NEG   = 1'b0,
  parameter logic RST_USED = 1'b0,
  parameter logic RST_NEG  = 1'b0,
  parameter logic RST_VAL  = 1'b0,
  parameter logic CE_PRIO  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic e,
  input  logic r,
  output logic exp_o,
  output logic vld_o
);

  logic exp_q, exp_d;
  logic vld_q, vld_d;
  logic en_act_s, rst_act_s;

  // Next-state: sync reset wins over enable unless the variant gates reset by enable.
  always_comb begin
    en_act_s  = EN_USED ? (e ^ EN_NEG) : 1'b1;
    rst_act_s = RST_USED ? (r ^ RST_NEG) : 1'b0;
    exp_d     = exp_q;
    vld_d     = vld_q;
    if (rst_act_s && (!CE_PRIO || en_act_s)) begin
      exp_d = RST_VAL;
      vld_d = 1'b1;
    end else if (en_act_s) begin
      exp_d = d;
      vld_d = 1'b1;
    end else begin
      exp_d = exp_q;
      vld_d = vld_q;
    end
  end

  generate
    if (CLK_NEG) begin : g_neg
      // Falling-edge model state.
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          exp_q <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          exp_q <= exp_d;
          vld_q <= vld_d;
        end
      end
    end else begin : g_pos
      // Rising-edge model state.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          exp_q <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          exp_q <= exp_d;
          vld_q <= vld_d;
        end
      end
    end
  endgenerate

  assign exp_o = exp_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/ff_legalize_checker.sv
// Golden-model checker for the legalized flop bank: compares the 27-bit Q bus
// against per-variant models and keeps sticky error, first-fail index and counts.
module ff_legalize_checker
  import ff_chk_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             DUT_D,
  input  logic             DUT_E,
  input  logic             DUT_R,
  input  logic [26:0]      Q,
  output logic             ERR,
  output logic [4:0]       ERR_IDX,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [26:0] exp_s, vld_s, mis_s;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    ff_chk_model #(
      .CLK_NEG (CLK_NEG_MASK[i]),
      .EN_USED (EN_USED_MASK[i]),
      .EN_NEG  (EN_NEG_MASK[i]),
      .RST_USED(RST_USED_MASK[i]),
      .RST_NEG (RST_NEG_MASK[i]),
      .RST_VAL (RST_VAL_MASK[i]),
      .CE_PRIO (CE_PRIO_MASK[i])
    ) u_model (
      .clk  (C),
      .rst_n(R),
      .d    (DUT_D),
      .e    (DUT_E),
      .r    (DUT_R),
      .exp_o(exp_s[i]),
      .vld_o(vld_s[i])
    );
  end

  assign mis_s = (exp_s ^ Q) & vld_s;

  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic             busy_q, busy_d;
  logic             cmp_s;

  // FSM transitions plus compare bookkeeping for the cycle being checked.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    idx_d     = idx_q;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;
    cmp_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) state_d = ST_CHECK;
        else    state_d = ST_IDLE;
      end
      ST_CHECK: begin
        if (!EN) begin
          state_d = ST_IDLE;
        end else begin
          cmp_s = 1'b1;
          if ((|mis_s) && STOP_ON_FAIL) state_d = ST_FAIL;
          else                          state_d = ST_CHECK;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    if (cmp_s) begin
      if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + CNT_ONE;
      else                      chk_cnt_d = chk_cnt_q;
      if (|mis_s) begin
        err_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
        else                      err_cnt_d = err_cnt_q;
        // Only the first failure records an index.
        if (!err_q) idx_d = lowest_set(mis_s);
        else        idx_d = idx_q;
      end else begin
        err_d = err_q;
      end
    end else begin
      chk_cnt_d = chk_cnt_q;
    end
    busy_d = (state_d == ST_CHECK);
  end

  // Checker state and outputs.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q   <= ST_IDLE;
      err_q     <= 1'b0;
      idx_q     <= 5'd0;
      err_cnt_q <= {CNT_W{1'b0}};
      chk_cnt_q <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign ERR     = err_q;
  assign ERR_IDX = idx_q;
  assign ERR_CNT = err_cnt_q;
  assign CHK_CNT = chk_cnt_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_ff_legalize_checker.sv
// Directed bench for ff_legalize_checker: a behavioural flop bank drives Q,
// with an XOR fault mask to inject mismatches on chosen bits.
module tb_ff_legalize_checker;

  logic C, R, EN, DD, DE, DR;
  logic [26:0] qp, qn, q_good, flip, q_bus;

  logic        err1, err2, err3, busy1, busy2, busy3;
  logic [4:0]  idx1, idx2, idx3;
  logic [15:0] ecnt1, ccnt1, ecnt2, ccnt2;
  logic [1:0]  ecnt3, ccnt3;

  int n_total = 0;
  int n_bad   = 0;

  ff_legalize_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) u_run (
    .C(C), .R(R), .EN(EN), .DUT_D(DD), .DUT_E(DE), .DUT_R(DR), .Q(q_bus),
    .ERR(err1), .ERR_IDX(idx1), .ERR_CNT(ecnt1), .CHK_CNT(ccnt1), .BUSY(busy1));

  ff_legalize_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) u_stop (
    .C(C), .R(R), .EN(EN), .DUT_D(DD), .DUT_E(DE), .DUT_R(DR), .Q(q_bus),
    .ERR(err2), .ERR_IDX(idx2), .ERR_CNT(ecnt2), .CHK_CNT(ccnt2), .BUSY(busy2));

  ff_legalize_checker #(.CNT_W(2), .STOP_ON_FAIL(1'b0)) u_sat (
    .C(C), .R(R), .EN(EN), .DUT_D(DD), .DUT_E(DE), .DUT_R(DR), .Q(q_bus),
    .ERR(err3), .ERR_IDX(idx3), .ERR_CNT(ecnt3), .CHK_CNT(ccnt3), .BUSY(busy3));

  initial C = 1'b0;
  always #5 C = ~C;

  function automatic logic is_neg(input int i);
    if (i == 1 || i == 4) return 1'b1;
    if (i >= 5 && i <= 10) return ((i - 5) % 3) == 2;
    if (i >= 11) return ((i - 11) % 4) == 3;
    return 1'b0;
  endfunction

  // Reference next-state, written per variant group.
  function automatic logic ref_next(input int i, input logic cur, input logic d,
                                    input logic e, input logic r);
    int k;
    logic en, ra, rv;
    if (i <= 1) return d;
    if (i <= 4) begin
      en = (i == 3) ? !e : e;
      return en ? d : cur;
    end
    if (i <= 10) begin
      k  = (i - 5) % 3;
      rv = (i >= 8);
      ra = (k == 1) ? !r : r;
      return ra ? rv : d;
    end
    k  = (i - 11) % 4;
    rv = (i >= 15 && i <= 18) || (i >= 23);
    en = (k == 1) ? !e : e;
    ra = (k == 2) ? !r : r;
    if (i <= 18) return ra ? rv : (en ? d : cur);
    return en ? (ra ? rv : d) : cur;
  endfunction

  always @(posedge C or negedge R) begin
    if (!R) qp <= '0;
    else for (int i = 0; i < 27; i++) qp[i] <= ref_next(i, qp[i], DD, DE, DR);
  end

  always @(negedge C or negedge R) begin
    if (!R) qn <= '0;
    else for (int i = 0; i < 27; i++) qn[i] <= ref_next(i, qn[i], DD, DE, DR);
  end

  always_comb begin
    q_good = '0;
    for (int i = 0; i < 27; i++) q_good[i] = is_neg(i) ? qn[i] : qp[i];
  end

  assign q_bus = q_good ^ flip;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge C);
      #2;
    end
  endtask

  task automatic set_in(input logic en, input logic d, input logic e, input logic r);
    EN = en; DD = d; DE = e; DR = r;
  endtask

  task automatic do_reset();
    flip = '0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    R = 1'b0;
    @(posedge C);
    #2;
    R = 1'b1;
  endtask

  task automatic test_reset();
    flip = '0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    R = 1'b0;
    #3;
    n_total++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b want 0", err1); end
    n_total++; if (idx1 !== 5'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", idx1); end
    n_total++; if (ecnt1 !== 16'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d want 0", ecnt1); end
    n_total++; if (ccnt1 !== 16'd0) begin n_bad++; $display("FAIL rst_chk_cnt: got %0d want 0", ccnt1); end
    n_total++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy1); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    n_total++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b want 1", busy1); end
    n_total++; if (ccnt1 !== 16'd0) begin n_bad++; $display("FAIL basic_enter_cnt: got %0d want 0", ccnt1); end
    tick(3);
    n_total++; if (ccnt1 !== 16'd3) begin n_bad++; $display("FAIL basic_chk_cnt: got %0d want 3", ccnt1); end
    n_total++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0b want 0", err1); end
  endtask

  task automatic test_vld_gating();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    flip = 27'd0;
    flip[2] = 1'b1; flip[4] = 1'b1; flip[19] = 1'b1;
    tick(4);
    n_total++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL vld_unloaded_err: got %0b want 0", err1); end
    n_total++; if (ccnt1 !== 16'd3) begin n_bad++; $display("FAIL vld_chk_cnt: got %0d want 3", ccnt1); end
    flip[5] = 1'b1;
    tick(1);
    flip = '0;
    n_total++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL vld_loaded_err: got %0b want 1", err1); end
    n_total++; if (idx1 !== 5'd5) begin n_bad++; $display("FAIL vld_loaded_idx: got %0d want 5", idx1); end
  endtask

  task automatic test_priority();
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    tick(2);
    set_in(1'b1, 1'b1, 1'b0, 1'b1);
    tick(2);
    n_total++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL prio_no_err: got %0b want 0", err1); end
    flip[19] = 1'b1;
    tick(1);
    flip = '0;
    n_total++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL prio_err: got %0b want 1", err1); end
    n_total++; if (idx1 !== 5'd19) begin n_bad++; $display("FAIL prio_idx: got %0d want 19", idx1); end
    n_total++; if (ecnt1 !== 16'd1) begin n_bad++; $display("FAIL prio_err_cnt: got %0d want 1", ecnt1); end
  endtask

  task automatic test_err_idx();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);
    flip[3] = 1'b1; flip[24] = 1'b1;
    tick(1);
    flip = '0;
    n_total++; if (idx1 !== 5'd3) begin n_bad++; $display("FAIL idx_first: got %0d want 3", idx1); end
    n_total++; if (ecnt1 !== 16'd1) begin n_bad++; $display("FAIL idx_err_cnt1: got %0d want 1", ecnt1); end
    tick(1);
    flip[1] = 1'b1;
    tick(1);
    flip = '0;
    n_total++; if (idx1 !== 5'd3) begin n_bad++; $display("FAIL idx_sticky: got %0d want 3", idx1); end
    n_total++; if (ecnt1 !== 16'd2) begin n_bad++; $display("FAIL idx_err_cnt2: got %0d want 2", ecnt1); end
    n_total++; if (ccnt1 !== 16'd4) begin n_bad++; $display("FAIL idx_chk_cnt: got %0d want 4", ccnt1); end
  endtask

  task automatic test_async_reset();
    R = 1'b0;
    #1;
    n_total++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %0b want 0", err1); end
    n_total++; if (idx1 !== 5'd0) begin n_bad++; $display("FAIL arst_idx: got %0d want 0", idx1); end
    n_total++; if (ecnt1 !== 16'd0) begin n_bad++; $display("FAIL arst_err_cnt: got %0d want 0", ecnt1); end
    n_total++; if (ccnt1 !== 16'd0) begin n_bad++; $display("FAIL arst_chk_cnt: got %0d want 0", ccnt1); end
    n_total++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %0b want 0", busy1); end
    flip = '0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    R = 1'b1;
    tick(2);
    n_total++; if (ccnt1 !== 16'd1) begin n_bad++; $display("FAIL arst_restart_cnt: got %0d want 1", ccnt1); end
    n_total++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL arst_restart_err: got %0b want 0", err1); end
  endtask

  task automatic test_stop_on_fail();
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    tick(5);
    flip[0] = 1'b1;
    tick(1);
    flip = '0;
    tick(10);
    n_total++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %0b want 0", busy2); end
    n_total++; if (ccnt2 !== 16'd5) begin n_bad++; $display("FAIL stop_chk_cnt: got %0d want 5", ccnt2); end
    n_total++; if (ecnt2 !== 16'd1) begin n_bad++; $display("FAIL stop_err_cnt: got %0d want 1", ecnt2); end
    n_total++; if (err2 !== 1'b1) begin n_bad++; $display("FAIL stop_err: got %0b want 1", err2); end
    n_total++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %0b want 1", busy1); end
    n_total++; if (ccnt1 !== 16'd15) begin n_bad++; $display("FAIL run_chk_cnt: got %0d want 15", ccnt1); end
    n_total++; if (ccnt3 !== 2'd3) begin n_bad++; $display("FAIL sat_chk_cnt: got %0d want 3", ccnt3); end
    n_total++; if (ecnt3 !== 2'd1) begin n_bad++; $display("FAIL sat_err_cnt: got %0d want 1", ecnt3); end
  endtask

  initial begin
    R = 1'b1;
    flip = '0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_basic();
    test_vld_gating();
    test_priority();
    test_err_idx();
    test_async_reset();
    test_stop_on_fail();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
